// File: rtl/sdr_pkg.sv
// Shared definitions for the TX/RX sample path: sample width, mapper
// states and the QPSK Gray constellation.
package sdr_pkg;

   localparam int SAMPLE_W = 12;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2
   } mapper_state_t;

   // Gray mapping: b1 sets the sign of I and b0 sets the sign of Q; result is {i, q}
   function automatic logic [2*SAMPLE_W-1:0] qpsk_map(
      input logic [1:0]                 dibit,
      input logic signed [SAMPLE_W-1:0] amp
   );
      logic signed [SAMPLE_W-1:0] v_i;
      logic signed [SAMPLE_W-1:0] v_q;
      v_i = dibit[1] ? -amp : amp;
      v_q = dibit[0] ? -amp : amp;
      return {v_i, v_q};
   endfunction

endpackage

// File: rtl/qpsk_symbol_mapper.sv
// Byte-to-QPSK mapper: prepends an alternating 00/11 preamble to each frame,
// then emits four Gray-mapped dibits per byte, MSB first, into the upsampler.
module qpsk_symbol_mapper
   import sdr_pkg::*;
#(
   parameter int AMP          = 1024,
   parameter int PREAMBLE_LEN = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          in_data,
   input  logic                in_last,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [SAMPLE_W-1:0] out_i,
   output logic [SAMPLE_W-1:0] out_q,
   output logic                out_last,
   output logic                out_valid,
   input  logic                out_ready
);

   localparam int                         CNT_W    = $clog2(PREAMBLE_LEN);
   localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(PREAMBLE_LEN - 1);
   localparam logic signed [SAMPLE_W-1:0] L_AMP    = SAMPLE_W'(AMP);

   mapper_state_t         r_state;
   logic [7:0]            r_byte;
   logic                  r_last;
   logic                  r_full;
   logic [1:0]            r_idx;
   logic [CNT_W-1:0]      r_cnt;
   logic [SAMPLE_W-1:0]   r_out_i;
   logic [SAMPLE_W-1:0]   r_out_q;
   logic                  r_out_last;
   logic                  r_out_valid;

   mapper_state_t         w_state_nxt;
   logic [7:0]            w_byte_nxt;
   logic                  w_last_nxt;
   logic                  w_full_nxt;
   logic [1:0]            w_idx_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  w_load;
   logic                  w_clear;
   logic [1:0]            w_load_dibit;
   logic                  w_load_last;
   logic [2*SAMPLE_W-1:0] w_sym;
   logic                  w_in_ready;
   logic                  w_cons;
   logic                  w_accept;
   logic [1:0]            w_idx_inc;

   function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] idx);
      case (idx)
         2'd0:    dibit_of = b[7:6];
         2'd1:    dibit_of = b[5:4];
         2'd2:    dibit_of = b[3:2];
         default: dibit_of = b[1:0];
      endcase
   endfunction

   // Accepting while dibit 3 drains lets the next byte follow with no bubble
   assign w_in_ready = (r_state == IDLE) ||
                       ((r_state == DATA) && !r_last &&
                        (!r_full || (r_out_valid && out_ready && (r_idx == 2'd3))));
   assign w_cons     = r_out_valid & out_ready;
   assign w_accept   = in_valid & w_in_ready;
   assign w_idx_inc  = r_idx + 2'd1;
   assign w_sym      = qpsk_map(w_load_dibit, L_AMP);

   // Next-state and output-register load decisions
   always_comb begin
      w_state_nxt  = r_state;
      w_byte_nxt   = r_byte;
      w_last_nxt   = r_last;
      w_full_nxt   = r_full;
      w_idx_nxt    = r_idx;
      w_cnt_nxt    = r_cnt;
      w_load       = 1'b0;
      w_clear      = 1'b0;
      w_load_dibit = 2'b00;
      w_load_last  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = PREAMBLE;
               w_byte_nxt  = in_data;
               w_last_nxt  = in_last;
               w_full_nxt  = 1'b1;
               w_idx_nxt   = 2'd0;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         PREAMBLE: begin
            if (!r_out_valid) begin
               w_load       = 1'b1;
               w_load_dibit = {2{r_cnt[0]}};
            end else if (w_cons) begin
               w_load = 1'b1;
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt  = DATA;
                  w_idx_nxt    = 2'd0;
                  w_load_dibit = r_byte[7:6];
               end else begin
                  w_cnt_nxt    = r_cnt + CNT_W'(1);
                  w_load_dibit = {2{~r_cnt[0]}};
               end
            end else begin
               w_load = 1'b0;
            end
         end
         DATA: begin
            if (w_cons) begin
               if (r_idx != 2'd3) begin
                  w_idx_nxt    = w_idx_inc;
                  w_load       = 1'b1;
                  w_load_dibit = dibit_of(r_byte, w_idx_inc);
                  w_load_last  = r_last && (w_idx_inc == 2'd3);
               end else if (r_last) begin
                  w_state_nxt = IDLE;
                  w_full_nxt  = 1'b0;
                  w_idx_nxt   = 2'd0;
                  w_clear     = 1'b1;
               end else if (w_accept) begin
                  w_byte_nxt   = in_data;
                  w_last_nxt   = in_last;
                  w_idx_nxt    = 2'd0;
                  w_load       = 1'b1;
                  w_load_dibit = in_data[7:6];
               end else begin
                  w_full_nxt = 1'b0;
                  w_idx_nxt  = 2'd0;
                  w_clear    = 1'b1;
               end
            end else if (!r_out_valid && r_full) begin
               w_load       = 1'b1;
               w_load_dibit = dibit_of(r_byte, r_idx);
               w_load_last  = r_last && (r_idx == 2'd3);
            end else if (!r_out_valid && w_accept) begin
               w_byte_nxt = in_data;
               w_last_nxt = in_last;
               w_full_nxt = 1'b1;
               w_idx_nxt  = 2'd0;
            end else begin
               w_load = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_full_nxt  = 1'b0;
            w_clear     = 1'b1;
         end
      endcase
   end

   // State, byte holding register and registered symbol outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_byte      <= 8'h00;
         r_last      <= 1'b0;
         r_full      <= 1'b0;
         r_idx       <= 2'd0;
         r_cnt       <= '0;
         r_out_i     <= '0;
         r_out_q     <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_byte  <= w_byte_nxt;
         r_last  <= w_last_nxt;
         r_full  <= w_full_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_load) begin
            r_out_i     <= w_sym[2*SAMPLE_W-1:SAMPLE_W];
            r_out_q     <= w_sym[SAMPLE_W-1:0];
            r_out_last  <= w_load_last;
            r_out_valid <= 1'b1;
         end else if (w_clear) begin
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
         end else begin
            r_out_valid <= r_out_valid;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_i     = r_out_i;
   assign out_q     = r_out_q;
   assign out_last  = r_out_last;
   assign out_valid = r_out_valid;

endmodule

// File: doc/qpsk_symbol_mapper.md
# qpsk_symbol_mapper

Byte-to-QPSK symbol mapper that feeds the 8x zero-order-hold upsampler in the TX chain. Accepts framed payload bytes over a valid/ready handshake and prepends a fixed preamble to each frame. Splits each byte into four dibits, MSB first, and emits Gray-mapped signed 12-bit I/Q symbols over a valid/ready handshake. The output interface matches the upsampler's input, so the two connect directly.

## Interface
Parameters:
- AMP, 1024: symbol magnitude, signed 12-bit, range 1..2047.
- PREAMBLE_LEN, 16: preamble symbols per frame; must be even and at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous active-high, one clock domain.
- in_data  in  8  payload byte.
- in_last  in  1  marks the final byte of a frame.
- in_valid  in  1  byte valid.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- out_i  out  12  signed I symbol.
- out_q  out  12  signed Q symbol.
- out_last  out  1  high with the final symbol of a frame.
- out_valid  out  1  symbol valid.
- out_ready  in  1  symbol consumed when out_valid & out_ready.

## Operation
- State machine with three states:
  - IDLE to PREAMBLE: on a byte accept; the byte and in_last are latched.
  - PREAMBLE to DATA: after PREAMBLE_LEN symbols are consumed.
  - DATA to IDLE: after dibit 3 of a byte latched with in_last=1 is consumed.
- Preamble pattern alternates dibits 00, 11, 00, 11, … and always starts with 00.
- Data dibits are taken MSB first: in_data[7:6], [5:4], [3:2], [1:0]. A 2-bit dibit index wraps 3 to 0.
- Gray mapping of dibit b1b0:
  - out_i = b1 ? -AMP : +AMP.
  - out_q = b0 ? -AMP : +AMP.
  - All values are signed 12-bit with no overflow, since |AMP| ≤ 2047.
- Internal byte register, flagged full or empty.
- in_ready is asserted (combinational, from registered state) when:
  - state is IDLE, or
  - state is DATA, the latched byte is not last, and either:
    - the byte register is empty, or
    - dibit 3 is being consumed in this cycle (out_valid & out_ready), which allows back-to-back bytes.
- In PREAMBLE, in_ready = 0.
- Underrun: in DATA with the byte register empty and no byte arriving, out_valid drops to 0 and the FSM waits in DATA. There is no timeout. The frame resumes on the next byte.
- out_last is asserted only with dibit 3 of the last byte. It is never asserted during the preamble.

## Timing
- Reset values:
  - state = IDLE; byte register empty.
  - out_valid = 0, out_last = 0, out_i = 0, out_q = 0.
  - in_ready = 1 once reset deasserts.
- Latency:
  - A byte accepted in IDLE on edge N gives the first preamble symbol with out_valid = 1 after edge N+1.
  - A byte accepted in DATA while the output is idle gives its first dibit after the next edge.
- Throughput: one symbol per clock while out_ready = 1 and the input keeps up, i.e. one byte per 4 clocks sustained.
- Output stability: while out_valid & !out_ready, out_i, out_q and out_last hold stable and the FSM does not advance.
- The last preamble symbol and the first data symbol are adjacent, with no bubble.
- Simultaneous consume-and-accept (dibit 3 consumed, new byte accepted in the same cycle): the next symbol is dibit 0 of the new byte on the following cycle.
- Reset asserted mid-frame: outputs clear immediately (asynchronously), the partial frame is dropped, and the block resumes in IDLE.

## Structure
- Shared package sdr_pkg holds:
  - SAMPLE_W = 12.
  - the mapper_state_t enum (IDLE, PREAMBLE, DATA).
  - a function qpsk_map(dibit, amp) returning the {i, q} pair, reusable by the RX slicer model.
- Single module with no sub-modules. The mapping lives in the package function.

## Test plan
- Reset, then a single-byte frame 0x1B with in_last=1, out_ready=1:
  - 16 preamble symbols (+1024,+1024), (-1024,-1024), …
  - then data symbols (+,+), (+,-), (-,+), (-,-).
  - out_last on the 20th symbol; in_ready = 1 afterwards.
- Three-byte frame 0xFF, 0x00, 0xA5 with continuous in_valid:
  - 12 data symbols with no gaps after the preamble.
  - in_ready pulses exactly on the dibit-3 cycle.
  - out_last only on symbol 12 of the data.
- Backpressure: out_ready low for 5 cycles mid-byte. Outputs are held unchanged and no dibit is skipped or duplicated.
- Underrun: the second byte is delayed 10 cycles. out_valid = 0 during the gap, and the frame resumes with the correct dibit 0.
- Reset asserted during the preamble (symbol 7): all outputs are 0 that cycle. A new frame afterwards starts with a full 16-symbol preamble.
- PREAMBLE_LEN=2, AMP=2047: the preamble is (+2047,+2047), (-2047,-2047), and out_i/out_q never wrap to positive for negative values.
